// File: rtl/uart_tx_arb.sv
// Round-robin arbiter/sequencer that shares one uart_tx between N_REQ byte streams.
// Messages are kept atomic from the first byte up to the byte marked last.
module uart_tx_arb #(
    parameter int unsigned N_REQ        = 4,
    parameter int unsigned LOCK_TIMEOUT = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [8*N_REQ-1:0]   req_data,
    input  logic [N_REQ-1:0]     req_last,
    output logic [N_REQ-1:0]     req_ready,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    input  logic                 tx_busy,
    output logic [N_REQ-1:0]     grant,
    output logic                 locked,
    output logic                 lock_drop,
    output logic [15:0]          tx_count
);

    localparam int unsigned PTR_W   = $clog2(N_REQ);
    localparam int unsigned TO_W    = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
    localparam int unsigned TO_LAST = (LOCK_TIMEOUT == 0) ? 0 : LOCK_TIMEOUT - 1;

    typedef enum logic [1:0] {ARB, ISSUE, WAIT_BUSY, WAIT_DONE} state_e;

    state_e             state_q;
    logic [PTR_W-1:0]   ptr_q;
    logic [PTR_W-1:0]   owner_q;
    logic [TO_W-1:0]    to_cnt_q;
    logic               locked_q;
    logic               lock_drop_q;
    logic               tx_start_q;
    logic [7:0]         tx_data_q;
    logic [N_REQ-1:0]   grant_q;
    logic [15:0]        tx_count_q;

    logic               sel_found;
    logic [PTR_W-1:0]   sel_idx;
    logic [PTR_W-1:0]   scan_idx;
    logic [7:0]         sel_data;
    logic               accept;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        if (32'(p) == N_REQ - 1) return '0;
        return p + PTR_W'(1);
    endfunction

    // Candidate selection: owner only while locked, else first valid from the RR pointer.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        scan_idx  = ptr_q;
        if (locked_q) begin
            sel_found = req_valid[owner_q];
            sel_idx   = owner_q;
        end else begin
            for (int unsigned k = 0; k < N_REQ; k++) begin
                if (!sel_found && req_valid[scan_idx]) begin
                    sel_found = 1'b1;
                    sel_idx   = scan_idx;
                end
                scan_idx = next_ptr(scan_idx);
            end
        end
    end

    assign req_ready = (!rst && state_q == ARB && !tx_busy && sel_found)
                       ? (N_REQ'(1) << sel_idx) : '0;
    assign sel_data  = req_data[{sel_idx, 3'b000} +: 8];
    assign accept    = |req_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ARB;
            ptr_q       <= '0;
            owner_q     <= '0;
            to_cnt_q    <= '0;
            locked_q    <= 1'b0;
            lock_drop_q <= 1'b0;
            tx_start_q  <= 1'b0;
            tx_data_q   <= '0;
            grant_q     <= '0;
            tx_count_q  <= '0;
        end else begin
            tx_start_q  <= 1'b0;
            lock_drop_q <= 1'b0;
            case (state_q)
                ARB: begin
                    if (accept) begin
                        tx_data_q  <= sel_data;
                        grant_q    <= N_REQ'(1) << sel_idx;
                        owner_q    <= sel_idx;
                        locked_q   <= !req_last[sel_idx];
                        to_cnt_q   <= '0;
                        tx_start_q <= 1'b1;
                        state_q    <= ISSUE;
                        if (req_last[sel_idx]) ptr_q <= next_ptr(sel_idx);
                    end else if (LOCK_TIMEOUT != 0 && locked_q && !req_valid[owner_q]) begin
                        // Idle owner: count toward a forced release of the message lock.
                        if (to_cnt_q == TO_W'(TO_LAST)) begin
                            locked_q    <= 1'b0;
                            grant_q     <= '0;
                            ptr_q       <= next_ptr(owner_q);
                            lock_drop_q <= 1'b1;
                            to_cnt_q    <= '0;
                        end else begin
                            to_cnt_q <= to_cnt_q + TO_W'(1);
                        end
                    end
                end
                ISSUE:     state_q <= WAIT_BUSY;
                WAIT_BUSY: if (tx_busy) state_q <= WAIT_DONE;
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        tx_count_q <= tx_count_q + 16'd1;
                        state_q    <= ARB;
                        if (!locked_q) grant_q <= '0;
                    end
                end
                default:   state_q <= ARB;
            endcase
        end
    end

    assign tx_start  = tx_start_q;
    assign tx_data   = tx_data_q;
    assign grant     = grant_q;
    assign locked    = locked_q;
    assign lock_drop = lock_drop_q;
    assign tx_count  = tx_count_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: behavioural uart_tx stand-in, queue-driven requesters,
// directed scenarios plus randomized messages checked against a message-level RR model.
module tb_uart_tx_arb;

    localparam int N = 4;

    logic           clk;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic           tx_start;
    logic [7:0]     tx_data;
    logic           tx_busy;
    logic [N-1:0]   grant;
    logic           locked;
    logic           lock_drop;
    logic [15:0]    tx_count;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int div      = 2;

    logic [8:0]  src_q [N][$];
    logic [8:0]  mdl_q [N][$];
    logic [11:0] tx_log [$];
    logic [N-1:0] acc_pend;

    uart_tx_arb #(.N_REQ(N), .LOCK_TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready),
        .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
        .grant(grant), .locked(locked), .lock_drop(lock_drop),
        .tx_count(tx_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // uart_tx stand-in: 10-bit frame, div cycles per bit, busy the cycle after start.
    logic       u_busy = 1'b0;
    int         u_cnt  = 0;
    logic [9:0] u_sh   = 10'h3FF;
    logic       u_line;
    always @(posedge clk) begin
        if (!u_busy) begin
            if (tx_start) begin
                u_busy <= 1'b1;
                u_sh   <= {1'b1, tx_data, 1'b0};
                u_cnt  <= 0;
            end
        end else if (u_cnt == 10 * div - 1) begin
            u_busy <= 1'b0;
        end else begin
            u_cnt <= u_cnt + 1;
        end
    end
    assign tx_busy = u_busy;
    assign u_line  = u_busy ? u_sh[4'(u_cnt / div)] : 1'b1;

    always @(negedge clk) if (tx_start) tx_log.push_back({grant, tx_data});

    // Requesters present their queue head and hold it until accepted.
    initial begin
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        acc_pend  = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++)
                if (acc_pend[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
            for (int i = 0; i < N; i++) begin
                if (src_q[i].size() > 0) begin
                    req_valid[i]       = 1'b1;
                    req_data[8*i +: 8] = src_q[i][0][7:0];
                    req_last[i]        = src_q[i][0][8];
                end else begin
                    req_valid[i]       = 1'b0;
                    req_data[8*i +: 8] = 8'h00;
                    req_last[i]        = 1'b0;
                end
            end
            #4;
            acc_pend = req_valid & req_ready;
        end
    end

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic wait_log(input int n);
        int t;
        t = 0;
        while (tx_log.size() < n && t < 5000) begin step(); t++; end
        n_checks++;
        if (tx_log.size() < n) begin
            n_errors++;
            $display("FAIL wait_log: got %0d bytes, required %0d", tx_log.size(), n);
        end
        step();
        step();
        t = 0;
        while (tx_busy && t < 5000) begin step(); t++; end
        n_checks++;
        if (tx_busy !== 1'b0) begin
            n_errors++;
            $display("FAIL wait_idle: tx_busy=%b required 0", tx_busy);
        end
        step();
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tx_log.delete();
        src_q[0].push_back({1'b1, 8'h5A});
        step();
        step();
        n_checks++;
        if ({req_ready, tx_start, tx_data, grant, locked, lock_drop, tx_count} !== '0) begin
            n_errors++;
            $display("FAIL reset_outputs: ready=%b start=%b data=%h grant=%b locked=%b drop=%b count=%h required all 0",
                     req_ready, tx_start, tx_data, grant, locked, lock_drop, tx_count);
        end
        rst = 1'b0;
        wait_log(1);
        n_checks++;
        if (tx_log.size() < 1 || tx_log[0] !== {4'b0001, 8'h5A}) begin
            n_errors++;
            $display("FAIL reset_first_byte: got %h required %h", tx_log.size() > 0 ? tx_log[0] : 12'h0, {4'b0001, 8'h5A});
        end
        n_checks++;
        if (tx_count !== 16'd1) begin
            n_errors++;
            $display("FAIL reset_count: tx_count=%0d required 1", tx_count);
        end
    endtask

    task automatic test_single_byte();
        int t, b;
        logic [9:0] bits;
        div = 4;
        do_reset();
        tx_log.delete();
        src_q[0].push_back({1'b1, 8'hA5});
        t = 0;
        while (req_ready == '0 && t < 20) begin step(); t++; end
        n_checks++;
        if (req_ready !== 4'b0001) begin
            n_errors++;
            $display("FAIL single_ready: req_ready=%b required 0001", req_ready);
        end
        step();
        n_checks++;
        if ({tx_start, tx_data} !== {1'b1, 8'hA5}) begin
            n_errors++;
            $display("FAIL single_start: tx_start=%b tx_data=%h required 1 a5", tx_start, tx_data);
        end
        step();
        n_checks++;
        if ({tx_start, tx_busy} !== 2'b01) begin
            n_errors++;
            $display("FAIL single_pulse: tx_start=%b tx_busy=%b required 0 1", tx_start, tx_busy);
        end
        b = cyc;
        bits = '0;
        for (int k = 0; k < 10; k++) begin
            while (cyc < b + k * div + div / 2) step();
            bits = {u_line, bits[9:1]};
        end
        n_checks++;
        if (bits !== 10'b1_1010_0101_0) begin
            n_errors++;
            $display("FAIL single_serial: frame=%b required 1101001010", bits);
        end
        wait_log(1);
        n_checks++;
        if (tx_count !== 16'd1) begin
            n_errors++;
            $display("FAIL single_count: tx_count=%0d required 1", tx_count);
        end
        // Pointer now sits at 1, so requester 1 beats requester 0.
        src_q[0].push_back({1'b1, 8'hB0});
        src_q[1].push_back({1'b1, 8'hB1});
        wait_log(3);
        n_checks++;
        if (tx_log.size() < 3 || tx_log[1] !== {4'b0010, 8'hB1} || tx_log[2] !== {4'b0001, 8'hB0}) begin
            n_errors++;
            $display("FAIL single_pointer: got %h %h required 2b1 1b0",
                     tx_log.size() > 1 ? tx_log[1] : 12'h0, tx_log.size() > 2 ? tx_log[2] : 12'h0);
        end
    endtask

    task automatic test_round_robin();
        logic [11:0] exp;
        div = 1;
        do_reset();
        tx_log.delete();
        for (int r = 0; r < 3; r++)
            for (int i = 0; i < N; i++) src_q[i].push_back({1'b1, 8'(8'h10 + i)});
        wait_log(12);
        for (int j = 0; j < 12; j++) begin
            exp = {4'(1 << (j % N)), 8'(8'h10 + (j % N))};
            n_checks++;
            if (j >= tx_log.size() || tx_log[j] !== exp) begin
                n_errors++;
                $display("FAIL rr_order[%0d]: got %h required %h", j, j < tx_log.size() ? tx_log[j] : 12'h0, exp);
            end
        end
    endtask

    task automatic test_atomicity();
        int t, idx;
        logic [11:0] exp [5];
        exp = '{{4'b0100, 8'h01}, {4'b0100, 8'h02}, {4'b0100, 8'h03}, {4'b0001, 8'h20}, {4'b0010, 8'h21}};
        div = 1;
        do_reset();
        tx_log.delete();
        src_q[2].push_back({1'b0, 8'h01});
        src_q[2].push_back({1'b0, 8'h02});
        src_q[2].push_back({1'b1, 8'h03});
        t = 0;
        while (req_ready[2] !== 1'b1 && t < 20) begin step(); t++; end
        src_q[0].push_back({1'b1, 8'h20});
        src_q[1].push_back({1'b1, 8'h21});
        t = 0;
        while (tx_log.size() < 5 && t < 2000) begin
            step();
            t++;
            if (tx_start) begin
                idx = tx_log.size() - 1;
                n_checks++;
                if (locked !== (idx < 2)) begin
                    n_errors++;
                    $display("FAIL atom_locked[%0d]: locked=%b required %b", idx, locked, idx < 2);
                end
            end
        end
        wait_log(5);
        for (int j = 0; j < 5; j++) begin
            n_checks++;
            if (j >= tx_log.size() || tx_log[j] !== exp[j]) begin
                n_errors++;
                $display("FAIL atom_order[%0d]: got %h required %h", j, j < tx_log.size() ? tx_log[j] : 12'h0, exp[j]);
            end
        end
    endtask

    task automatic test_lock_timeout();
        int t, d, drop_cyc;
        logic prev_locked, stray_ready;
        div = 1;
        do_reset();
        tx_log.delete();
        src_q[1].push_back({1'b0, 8'h55});
        t = 0;
        while (req_ready[1] !== 1'b1 && t < 20) begin step(); t++; end
        src_q[2].push_back({1'b1, 8'h66});
        t = 0;
        while (!tx_busy && t < 20) begin step(); t++; end
        t = 0;
        while (tx_busy && t < 100) begin step(); t++; end
        d = cyc;
        prev_locked = locked;
        stray_ready = 1'b0;
        t = 0;
        while (lock_drop !== 1'b1 && t < 40) begin
            prev_locked = locked;
            if (req_ready != '0) stray_ready = 1'b1;
            step();
            t++;
        end
        drop_cyc = cyc;
        n_checks++;
        if (drop_cyc != d + 9) begin
            n_errors++;
            $display("FAIL timeout_when: lock_drop at +%0d cycles required +9", drop_cyc - d);
        end
        n_checks++;
        if ({prev_locked, stray_ready} !== 2'b10) begin
            n_errors++;
            $display("FAIL timeout_hold: locked_before=%b stray_ready=%b required 1 0", prev_locked, stray_ready);
        end
        n_checks++;
        if ({grant, locked} !== 5'b0) begin
            n_errors++;
            $display("FAIL timeout_release: grant=%b locked=%b required 0 0", grant, locked);
        end
        step();
        n_checks++;
        if (lock_drop !== 1'b0) begin
            n_errors++;
            $display("FAIL timeout_pulse: lock_drop=%b required 0", lock_drop);
        end
        wait_log(2);
        n_checks++;
        if (tx_log.size() < 2 || tx_log[0] !== {4'b0010, 8'h55} || tx_log[1] !== {4'b0100, 8'h66}) begin
            n_errors++;
            $display("FAIL timeout_next: got %h %h required 255 466",
                     tx_log.size() > 0 ? tx_log[0] : 12'h0, tx_log.size() > 1 ? tx_log[1] : 12'h0);
        end
    endtask

    task automatic test_reset_mid_frame();
        int t;
        logic stray_ready;
        div = 2;
        do_reset();
        tx_log.delete();
        src_q[0].push_back({1'b1, 8'hC3});
        t = 0;
        while (!tx_busy && t < 20) begin step(); t++; end
        for (int k = 0; k < 3 * div + 1; k++) step();
        src_q[1].push_back({1'b1, 8'h3C});
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++;
        if ({tx_start, tx_data, grant, locked, lock_drop, tx_count, tx_busy} !== {31'b0, 1'b1}) begin
            n_errors++;
            $display("FAIL midrst_outputs: start=%b data=%h grant=%b locked=%b drop=%b count=%h busy=%b required 0s busy=1",
                     tx_start, tx_data, grant, locked, lock_drop, tx_count, tx_busy);
        end
        stray_ready = 1'b0;
        t = 0;
        while (tx_busy && t < 100) begin
            if (req_ready != '0) stray_ready = 1'b1;
            step();
            t++;
        end
        n_checks++;
        if (stray_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL midrst_ready: req_ready seen during old frame, required none");
        end
        wait_log(2);
        n_checks++;
        if (tx_log.size() < 2 || tx_log[1] !== {4'b0010, 8'h3C} || tx_count !== 16'd1) begin
            n_errors++;
            $display("FAIL midrst_next: got %h count=%0d required 23c count=1",
                     tx_log.size() > 1 ? tx_log[1] : 12'h0, tx_count);
        end
    endtask

    task automatic test_counter_wrap();
        div = 1;
        do_reset();
        tx_log.delete();
        force dut.tx_count_q = 16'hFFFF;
        step();
        release dut.tx_count_q;
        step();
        n_checks++;
        if (tx_count !== 16'hFFFF) begin
            n_errors++;
            $display("FAIL wrap_preload: tx_count=%h required ffff", tx_count);
        end
        src_q[3].push_back({1'b1, 8'h77});
        wait_log(1);
        n_checks++;
        if (tx_count !== 16'h0000 || tx_log.size() < 1 || tx_log[0] !== {4'b1000, 8'h77}) begin
            n_errors++;
            $display("FAIL wrap_count: tx_count=%h byte=%h required 0000 877",
                     tx_count, tx_log.size() > 0 ? tx_log[0] : 12'h0);
        end
    endtask

    task automatic test_random();
        logic [11:0] exp [$];
        logic [8:0]  e;
        int ptr, found, nmsg, len;
        div = int'($urandom_range(1, 2));
        do_reset();
        tx_log.delete();
        for (int i = 0; i < N; i++) begin
            nmsg = int'($urandom_range(0, 3));
            for (int m = 0; m < nmsg; m++) begin
                len = int'($urandom_range(1, 3));
                for (int b = 0; b < len; b++) begin
                    e = {b == len - 1, 8'($urandom)};
                    src_q[i].push_back(e);
                    mdl_q[i].push_back(e);
                end
            end
        end
        // Whole messages leave in round-robin order starting after the last finisher.
        ptr = 0;
        found = 0;
        while (found >= 0) begin
            found = -1;
            for (int k = 0; k < N; k++)
                if (found < 0 && mdl_q[(ptr + k) % N].size() > 0) found = (ptr + k) % N;
            if (found >= 0) begin
                do begin
                    e = mdl_q[found].pop_front();
                    exp.push_back({4'(1 << found), e[7:0]});
                end while (!e[8]);
                ptr = (found + 1) % N;
            end
        end
        wait_log(exp.size());
        for (int j = 0; j < exp.size(); j++) begin
            n_checks++;
            if (j >= tx_log.size() || tx_log[j] !== exp[j]) begin
                n_errors++;
                $display("FAIL rand_order[%0d]: got %h required %h", j, j < tx_log.size() ? tx_log[j] : 12'h0, exp[j]);
            end
        end
        n_checks++;
        if (tx_count !== 16'(exp.size()) || tx_log.size() != exp.size()) begin
            n_errors++;
            $display("FAIL rand_count: tx_count=%0d logged=%0d required %0d", tx_count, tx_log.size(), exp.size());
        end
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_single_byte();
        test_round_robin();
        test_atomicity();
        test_lock_timeout();
        test_reset_mid_frame();
        test_counter_wrap();
        for (int r = 0; r < 4; r++) test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
